// File: rtl/friscv_apb_master.sv
// -----------------------------------------------------------------------------
// friscv_apb_master
//
// Bridge from the hart's single-beat load/store path to an APB-style peripheral
// bus (CLINT and similar). One transaction is in flight at a time:
//   IDLE   -> accept a request, launch the access (mst_en = 1)
//   ACCESS -> hold the access until the peripheral's one-cycle mst_ready pulse
//   RESP   -> hold the response until the core consumes it (rsp_ready)
//
// Optional feature (macro FRISCV_APB_TIMEOUT_EN):
//   When defined, an ACCESS that sees no mst_ready for TIMEOUT cycles is
//   aborted and answered with rsp_err = 1. When undefined, ACCESS waits
//   indefinitely and rsp_err is tied to 0.
//
// Parameters:
//   ADDRW    APB address width
//   XLEN     data width (32 or 64)
//   TIMEOUT  maximum ACCESS cycles before abort (>= 2)
//
// Ports:
//   aclk, aresetn (async, active-high), srst (sync, active-high)
//   req_valid/req_ready/req_wr/req_addr/req_wdata/req_strb : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                  : response channel
//   mst_en/mst_wr/mst_addr/mst_wdata/mst_strb              : APB request
//   mst_rdata/mst_ready                                    : APB completion
// -----------------------------------------------------------------------------
module friscv_apb_master #(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               srst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [ADDRW-1:0]   req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    input  logic [XLEN/8-1:0]  req_strb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               rsp_err,
    output logic               mst_en,
    output logic               mst_wr,
    output logic [ADDRW-1:0]   mst_addr,
    output logic [XLEN-1:0]    mst_wdata,
    output logic [XLEN/8-1:0]  mst_strb,
    input  logic [XLEN-1:0]    mst_rdata,
    input  logic               mst_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic                mst_en_r,    mst_en_nxt_s;
    logic                mst_wr_r,    mst_wr_nxt_s;
    logic [ADDRW-1:0]    mst_addr_r,  mst_addr_nxt_s;
    logic [XLEN-1:0]     mst_wdata_r, mst_wdata_nxt_s;
    logic [XLEN/8-1:0]   mst_strb_r,  mst_strb_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic [XLEN-1:0]     rsp_rdata_r, rsp_rdata_nxt_s;

    logic                tmo_hit_s;
    logic                done_s;
    logic                abort_s;

    // Peripheral completion is only honoured while an access is outstanding;
    // a ready arriving together with the timeout limit wins over the abort.
    assign done_s  = (state_r == ACCESS) && mst_ready;
    assign abort_s = (state_r == ACCESS) && !mst_ready && tmo_hit_s;

`ifdef FRISCV_APB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] tmo_cnt_r;
    logic            rsp_err_r;

    // Counter value TIMEOUT-1 marks the last ACCESS cycle allowed.
    assign tmo_hit_s = (tmo_cnt_r == CNTW'(TIMEOUT - 1));

    // Timeout counter: zero while idle, counts ACCESS cycles without ready.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            tmo_cnt_r <= {CNTW{1'b0}};
        end else if (srst) begin
            tmo_cnt_r <= {CNTW{1'b0}};
        end else if (state_r == IDLE) begin
            tmo_cnt_r <= {CNTW{1'b0}};
        end else if ((state_r == ACCESS) && !mst_ready && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNTW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Error flag: set on abort, cleared on a normal completion.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            rsp_err_r <= 1'b0;
        end else if (srst) begin
            rsp_err_r <= 1'b0;
        end else if (done_s) begin
            rsp_err_r <= 1'b0;
        end else if (abort_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_r <= IDLE;
        end else if (srst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (done_s || abort_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output decode: next values of the registered bus/response outputs.
    always_comb begin
        mst_en_nxt_s    = mst_en_r;
        mst_wr_nxt_s    = mst_wr_r;
        mst_addr_nxt_s  = mst_addr_r;
        mst_wdata_nxt_s = mst_wdata_r;
        mst_strb_nxt_s  = mst_strb_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    mst_en_nxt_s    = 1'b1;
                    mst_wr_nxt_s    = req_wr;
                    mst_addr_nxt_s  = req_addr;
                    mst_wdata_nxt_s = req_wdata;
                    mst_strb_nxt_s  = req_strb;
                end else begin
                    mst_en_nxt_s    = mst_en_r;
                end
            end
            ACCESS: begin
                // en drops on the edge that samples ready so the peripheral
                // never sees a second access.
                if (done_s) begin
                    mst_en_nxt_s    = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = mst_wr_r ? {XLEN{1'b0}} : mst_rdata;
                end else if (abort_s) begin
                    mst_en_nxt_s    = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = {XLEN{1'b0}};
                end else begin
                    mst_en_nxt_s    = mst_en_r;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                end else begin
                    rsp_valid_nxt_s = rsp_valid_r;
                end
            end
            default: begin
                mst_en_nxt_s    = 1'b0;
                mst_wr_nxt_s    = 1'b0;
                mst_addr_nxt_s  = {ADDRW{1'b0}};
                mst_wdata_nxt_s = {XLEN{1'b0}};
                mst_strb_nxt_s  = {(XLEN/8){1'b0}};
                rsp_valid_nxt_s = 1'b0;
                rsp_rdata_nxt_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            mst_en_r    <= 1'b0;
            mst_wr_r    <= 1'b0;
            mst_addr_r  <= {ADDRW{1'b0}};
            mst_wdata_r <= {XLEN{1'b0}};
            mst_strb_r  <= {(XLEN/8){1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
        end else if (srst) begin
            mst_en_r    <= 1'b0;
            mst_wr_r    <= 1'b0;
            mst_addr_r  <= {ADDRW{1'b0}};
            mst_wdata_r <= {XLEN{1'b0}};
            mst_strb_r  <= {(XLEN/8){1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
        end else begin
            mst_en_r    <= mst_en_nxt_s;
            mst_wr_r    <= mst_wr_nxt_s;
            mst_addr_r  <= mst_addr_nxt_s;
            mst_wdata_r <= mst_wdata_nxt_s;
            mst_strb_r  <= mst_strb_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
        end
    end

    assign req_ready = (state_r == IDLE);
    assign mst_en    = mst_en_r;
    assign mst_wr    = mst_wr_r;
    assign mst_addr  = mst_addr_r;
    assign mst_wdata = mst_wdata_r;
    assign mst_strb  = mst_strb_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: doc/friscv_apb_master.md
# friscv_apb_master

Bridge that turns single-beat load/store requests from the core's data path into APB-style register accesses for peripherals such as the CLINT. Sits between the hart's memory interface and the peripheral bus. Drives the `en`/`wr`/`addr`/`wdata`/`strb` request and waits for the peripheral's single-cycle `ready` pulse. Returns read data and an error flag on a valid/ready response channel, with one transaction in flight at a time.

## Interface
Parameters:
- `ADDRW`, 16, APB address width
- `XLEN`, 32, data width; 32 or 64
- `TIMEOUT`, 255, maximum ACCESS cycles before abort; must be ≥ 2

Ports:
- `aclk`  in  1  core clock
- `aresetn`  in  1  reset; **asynchronous, active-high** (asserted = 1)
- `srst`  in  1  synchronous reset, active-high, same effect as `aresetn`
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted
- `req_wr`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDRW  byte address
- `req_wdata`  in  XLEN  write data
- `req_strb`  in  XLEN/8  byte enables
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  XLEN  read data; 0 for writes and errors
- `rsp_err`  out  1  transaction aborted by timeout
- `mst_en`  out  1  APB access enable
- `mst_wr`  out  1  APB write
- `mst_addr`  out  ADDRW  APB address
- `mst_wdata`  out  XLEN  APB write data
- `mst_strb`  out  XLEN/8  APB byte strobes
- `mst_rdata`  in  XLEN  APB read data, valid with `mst_ready`
- `mst_ready`  in  1  one-cycle completion pulse from the peripheral

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1, driven combinationally from the state.
  - When `req_valid` is high, register `wr`/`addr`/`wdata`/`strb` onto the `mst_*` outputs, set `mst_en` = 1, clear the timeout counter, and go to ACCESS.
- **ACCESS**
  - `mst_en` and all `mst_*` fields are held stable.
  - On `mst_ready` = 1:
    - clear `mst_en`;
    - for reads, set `rsp_rdata` = `mst_rdata`; for writes, set it to 0;
    - set `rsp_err` = 0 and `rsp_valid` = 1;
    - go to RESP.
- **RESP**
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are held stable.
  - When `rsp_ready` is high, clear `rsp_valid` and go to IDLE.
- `mst_ready` outside ACCESS is ignored.
- `req_valid` outside IDLE is not accepted (`req_ready` = 0).
- Reset (either source), including mid-ACCESS or mid-RESP:
  - state goes to IDLE;
  - `mst_en`, `mst_wr`, `rsp_valid` and `rsp_err` = 0;
  - `mst_addr`, `mst_wdata`, `mst_strb` and `rsp_rdata` = 0;
  - the in-flight transaction is discarded.
- After reset, `req_ready` = 1 because the state is IDLE.

## Timing
- Request handshake at edge T: `mst_en` = 1 during cycle T+1.
- With a peripheral that pulses `mst_ready` during the cycle after it first sees `en` (cycle T+2):
  - `mst_en` = 0 and `rsp_valid` = 1 from cycle T+3;
  - best-case request-to-response latency is 3 cycles.
- `mst_en` drops on the same edge that samples `mst_ready`, so a peripheral never sees `en` high after its `ready` cycle. This prevents a repeated access.
- With `rsp_ready` held high, `rsp_valid` lasts exactly 1 cycle and IDLE is re-entered the next cycle. Minimum spacing between accepted requests is 4 cycles.

## Configuration
- Macro: `FRISCV_APB_TIMEOUT_EN`.
- **Defined**
  - A counter of width $clog2(TIMEOUT+1) increments on each ACCESS cycle without `mst_ready`.
  - When it reaches `TIMEOUT`-1 without `mst_ready`, the block aborts: clears `mst_en`, sets `rsp_err` = 1 and `rsp_rdata` = 0, asserts `rsp_valid`, and goes to RESP.
  - If `mst_ready` arrives on that same cycle, ready wins and `rsp_err` = 0.
- **Undefined**
  - No counter is present; ACCESS waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- **Read.** Request a read at address 0x0008; the peripheral pulses `mst_ready` with `mst_rdata` = 0x1234_5678 at T+2.
  - Expect `rsp_valid` at T+3 with `rsp_rdata` = 0x1234_5678 and `rsp_err` = 0.
  - Expect `mst_en` high for exactly 2 cycles.
- **Write.** Request a write at address 0x0010 with `req_wdata` = 0xDEAD_BEEF and `req_strb` = 4'b0101.
  - Expect `mst_wr` = 1 and `mst_strb` = 4'b0101 held throughout ACCESS.
  - Expect `rsp_rdata` = 0 and `rsp_err` = 0.
- **Backpressure.** Hold `rsp_ready` = 0 for 5 cycles, then drive it high.
  - Expect `rsp_valid` and `rsp_rdata` stable throughout, `req_ready` = 0, and new `req_valid` pulses ignored.
  - Expect IDLE one cycle after `rsp_ready` goes high.
- **Timeout** (macro defined, `TIMEOUT` = 8). The peripheral never responds.
  - Expect `mst_en` to drop after 8 ACCESS cycles, with `rsp_err` = 1 and `rsp_rdata` = 0.
  - Repeat with `mst_ready` on exactly the 8th cycle: expect `rsp_err` = 0.
- **Reset mid-ACCESS.** Assert `aresetn` = 1 asynchronously while `mst_en` = 1.
  - Expect `mst_en` = 0 and `rsp_valid` = 0 immediately, without waiting for a clock edge.
  - Expect `req_ready` = 1 after release.
  - Repeat with `srst`: expect the same state, taking effect at the next edge.
- **Back-to-back.** Issue 4 requests with `req_valid` held high and `rsp_ready` = 1.
  - Expect 4 responses in order, accepted at 4-cycle intervals.
  - Expect no `mst_en` assertion overlapping a `mst_ready` cycle of the previous access.
